mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
- Parametrised successor to the single-bank 256x16 SB_RAM40_4K wrapper.
- Cascades NUM_BANKS SB_RAM40_4K primitives into one word-addressed store.
- Adds per-byte write enables and a byte-addressed burst-read engine.
- The burst engine streams bytes out over a valid/ready handshake.
- Sits between the memory-test controller (UART/SPI command side) and the embedded RAM.

Parameters:
- NUM_BANKS, 2, number of 256x16 SB_RAM40_4K instances; power of two, 1..16.
- WADDR_W, 8+log2(NUM_BANKS), word address width (derived localparam, not overridable).
- MAX_BURST, 16, maximum burst length in bytes; LEN_W = log2(MAX_BURST)+1.
- INIT_FILE, "", optional $readmemh image for simulation only; empty means all zero.

Ports:
- clk  in  1  single clock; drives all RAM RCLK/WCLK.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- wr_en  in  1  word write strobe, sampled at the rising edge of clk.
- wr_addr  in  WADDR_W  word address; upper log2(NUM_BANKS) bits select the bank.
- wr_data  in  16  write word.
- wr_be  in  2  byte enables; bit1 = [15:8], bit0 = [7:0]. Maps to MASK as 0 = written.
- rd_start  in  1  burst request; accepted only in IDLE.
- rd_addr  in  WADDR_W+1  starting byte address; bit0 = 1 selects the high byte.
- rd_len  in  LEN_W  burst length in bytes, 0..MAX_BURST.
- i_ready  in  1  downstream accepts the byte.
- o_data_byte  out  8  streamed byte.
- o_valid  out  1  o_data_byte is valid.
- rd_busy  out  1  a burst is in progress.
- rd_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: state IDLE; o_valid, o_data_byte, rd_busy and rd_done all 0. RAM contents are not cleared. An asserted reset aborts any burst immediately.
- Writes are independent of the read engine:
  - Accepted on any edge with wr_en = 1 and wr_be != 0.
  - Only the addressed bank's WE is asserted.
  - wr_be = 00 performs no write.
  - Written data is readable by a FETCH issued on a later edge.
- Burst FSM states: IDLE, FETCH, CAPTURE, EMIT, DONE.
- IDLE:
  - On rd_start=1, latch byte pointer = rd_addr and remaining = rd_len.
  - If rd_len=0, go to DONE; otherwise go to FETCH.
  - rd_busy goes to 1 on that edge.
- FETCH (1 cycle): RE is asserted to the bank given by pointer[WADDR_W:9], at word address pointer[8:1]. The bank index is registered for the output mux.
- CAPTURE (1 cycle): the selected bank's RDATA is latched into the word buffer; go to EMIT.
- EMIT:
  - o_valid=1; o_data_byte = buffer[15:8] if pointer[0] else buffer[7:0].
  - o_data_byte is held stable while i_ready=0.
  - On o_valid & i_ready: pointer+1, remaining-1.
    - If remaining reaches 0, go to DONE.
    - Else if pointer[0] was 1 (word boundary crossed), go to FETCH.
    - Else stay in EMIT (high byte of the same word).
- DONE (1 cycle): rd_done=1, o_valid=0, rd_busy=0 next edge, return to IDLE.
- Latency: the first byte is valid 3 edges after the accepting edge. Each new word costs 2 bubble cycles (FETCH, CAPTURE).
- The pointer wraps modulo 2^(WADDR_W+1): the last byte of the last bank is followed by byte 0 of bank 0.
- rd_start while not IDLE is ignored; no queueing.
- rd_len > MAX_BURST is clamped to MAX_BURST.
- Same-edge write and FETCH to the same word: RAM result undefined without the optional feature; the bench must avoid this case.

Optional Feature:
- Macro: MEM_RD_BYPASS_EN.
- Defined:
  - The write address, data and byte enables are registered alongside FETCH.
  - In CAPTURE, if a write hit the fetched word on the FETCH edge, the buffer takes the written bytes per wr_be merged with RDATA for unwritten bytes.
  - Read-during-write is therefore deterministic (new data).
- Undefined: no bypass logic; behaviour as above.

Test Plan:
- Write word 0x00=0xA55A with be=11, then burst addr 0x000, len 2 -> bytes 0x5A, 0xA5; rd_done pulses once; first o_valid 3 edges after accept.
- Write 0x01=0x1234 with be=01, then write 0x01=0xAB00 with be=10; burst addr 0x003, len 1 -> single byte 0xAB; low byte remains 0x34 (burst at 0x002 -> 0x34).
- NUM_BANKS=2: write word 0x1FF=0xBEEF and word 0x000=0xCAFE; burst addr 0x3FE, len 4 -> 0xEF, 0xBE, 0xFE, 0xCA (bank crossing and wrap).
- Burst len 16 with i_ready toggling 1,0,0,1... -> o_data_byte stable during stalls; exactly 16 handshakes; rd_start during the burst is ignored.
- rd_len=0 -> no o_valid; rd_done pulses 2 edges after accept. Reset asserted mid-EMIT -> o_valid, rd_busy 0 immediately; RAM data intact on a re-read.
- MEM_RD_BYPASS_EN: same-edge write 0x5=0x7777 with be=11 and FETCH of word 0x5 -> bytes 0x77, 0x77.

Source files
------------

// File: rtl/mem_burst_reader_if.sv
// mem_burst_reader_if: write port, burst-read request and byte-stream handshake of mem_burst_reader
// Ports:
//   wr_en/wr_addr/wr_data/wr_be    word write with per-byte enables
//   rd_start/rd_addr/rd_len        burst request; byte start address and length
//   i_ready/o_data_byte/o_valid    byte stream (valid/ready)
//   rd_busy/rd_done                burst status
// Modports: slave for the reader, master for the controller driving it.
interface mem_burst_reader_if #(
  parameter int NUM_BANKS = 2,
  parameter int MAX_BURST = 16
);
  localparam int WADDR_W = 8 + $clog2(NUM_BANKS);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  logic wr_en;
  logic [WADDR_W-1:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0] wr_be;
  logic rd_start;
  logic [WADDR_W:0] rd_addr;
  logic [LEN_W-1:0] rd_len;
  logic i_ready;
  logic [7:0] o_data_byte;
  logic o_valid;
  logic rd_busy;
  logic rd_done;
  modport slave (
    input wr_en, wr_addr, wr_data, wr_be, rd_start, rd_addr, rd_len, i_ready,
    output o_data_byte, o_valid, rd_busy, rd_done
  );
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_start, rd_addr, rd_len, i_ready,
    input o_data_byte, o_valid, rd_busy, rd_done
  );
endinterface

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: NUM_BANKS cascaded 256x16 RAM banks with byte-enable writes and a byte-addressed burst reader
// Ports:
//   clk    single clock for the RAM banks and the burst engine
//   reset  asynchronous active-low reset of the burst engine (RAM contents kept)
//   bus    mem_burst_reader_if.slave: write port, burst request, byte stream, status
// Optional: define MEM_RD_BYPASS_EN to forward a write that lands on the word being fetched.
// Timing: rd_done is registered out of DONE, so it pulses in the cycle after DONE with rd_busy already low.
module mem_burst_reader #(
  parameter int NUM_BANKS = 2,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic reset,
  mem_burst_reader_if.slave bus
);
  localparam int WADDR_W = 8 + $clog2(NUM_BANKS);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [WADDR_W:0] ptr;
  logic [LEN_W-1:0] rem, len_c;
  logic [15:0] buf_q, cap_word;
  logic [BW-1:0] bank_q, rd_bank, wr_bank;
  logic [NUM_BANKS-1:0][15:0] rdata;
  logic rd_done_q;
  assign len_c = bus.rd_len > LEN_W'(MAX_BURST) ? LEN_W'(MAX_BURST) : bus.rd_len;
  assign rd_bank = BW'(ptr >> 9);
  assign wr_bank = BW'(bus.wr_addr >> 8);
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [15:0] mem [256];
    logic [15:0] q;
    logic we, re;
    assign we = bus.wr_en && bus.wr_be != 2'b00 && wr_bank == BW'(b);
    assign re = state == FETCH && rd_bank == BW'(b);
    always_ff @(posedge clk) begin
      if (we && bus.wr_be[0]) mem[bus.wr_addr[7:0]][7:0] <= bus.wr_data[7:0];
      if (we && bus.wr_be[1]) mem[bus.wr_addr[7:0]][15:8] <= bus.wr_data[15:8];
      if (re) q <= mem[ptr[8:1]];
    end
    assign rdata[b] = q;
  end
`ifdef MEM_RD_BYPASS_EN
  logic byp_hit;
  logic [15:0] byp_data;
  logic [1:0] byp_be;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      byp_hit <= 1'b0;
      byp_data <= '0;
      byp_be <= '0;
    end else if (state == FETCH) begin
      byp_hit <= bus.wr_en && bus.wr_addr == ptr[WADDR_W:1];
      byp_data <= bus.wr_data;
      byp_be <= bus.wr_be;
    end
  assign cap_word = {byp_hit && byp_be[1] ? byp_data[15:8] : rdata[bank_q][15:8],
                     byp_hit && byp_be[0] ? byp_data[7:0] : rdata[bank_q][7:0]};
`else
  assign cap_word = rdata[bank_q];
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      rem <= '0;
      buf_q <= '0;
      bank_q <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state <= state_n;
      rd_done_q <= state == DONE;
      if (state == IDLE && bus.rd_start) begin
        ptr <= bus.rd_addr;
        rem <= len_c;
      end
      if (state == FETCH) bank_q <= rd_bank;
      if (state == CAPTURE) buf_q <= cap_word;
      if (state == EMIT && bus.i_ready) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
      end
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !bus.rd_start ? IDLE : len_c == '0 ? DONE : FETCH;
      FETCH: state_n = CAPTURE;
      CAPTURE: state_n = EMIT;
      EMIT: state_n = !bus.i_ready ? EMIT : rem == LEN_W'(1) ? DONE : ptr[0] ? FETCH : EMIT;
      default: state_n = IDLE;
    endcase
    bus.o_valid = state == EMIT;
    bus.o_data_byte = state != EMIT ? 8'h00 : ptr[0] ? buf_q[15:8] : buf_q[7:0];
    bus.rd_busy = state != IDLE;
    bus.rd_done = rd_done_q;
  end
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: directed self-checking bench for mem_burst_reader (NUM_BANKS=2, MAX_BURST=16)
module tb_mem_burst_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_burst_reader_if #(.NUM_BANKS(2), .MAX_BURST(16)) bus ();
  mem_burst_reader #(.NUM_BANKS(2), .MAX_BURST(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_write(logic [8:0] addr, logic [15:0] data, logic [1:0] be);
    bus.wr_en = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.wr_be = be;
    step();
    bus.wr_en = 1'b0;
  endtask
  task automatic start(logic [9:0] addr, logic [4:0] len);
    bus.rd_start = 1'b1;
    bus.rd_addr = addr;
    bus.rd_len = len;
    step();
    bus.rd_start = 1'b0;
  endtask
  task automatic get_byte(string tag, logic [7:0] exp);
    int n = 0;
    while (!bus.o_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, " valid"}, bus.o_valid, 1);
    chk(tag, bus.o_data_byte, exp);
    step();
  endtask
  task automatic wait_done(string tag);
    int n = 0;
    while (!bus.rd_done && n < 20) begin
      step();
      n++;
    end
    chk(tag, bus.rd_done, 1);
    step();
  endtask
  initial begin
    int hs, cyc;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be = '0;
    bus.rd_start = 1'b0;
    bus.rd_addr = '0;
    bus.rd_len = '0;
    bus.i_ready = 1'b1;
    step();
    step();
    chk("rst o_valid", bus.o_valid, 0);
    chk("rst o_data_byte", bus.o_data_byte, 0);
    chk("rst rd_busy", bus.rd_busy, 0);
    chk("rst rd_done", bus.rd_done, 0);
    reset = 1'b1;
    step();
    do_write(9'h000, 16'hA55A, 2'b11);
    start(10'h000, 5'd2);
    chk("t1 busy after accept", bus.rd_busy, 1);
    chk("t1 no valid in fetch", bus.o_valid, 0);
    step();
    chk("t1 no valid in capture", bus.o_valid, 0);
    step();
    chk("t1 valid 3rd edge", bus.o_valid, 1);
    chk("t1 byte0", bus.o_data_byte, 8'h5A);
    step();
    chk("t1 byte1 valid", bus.o_valid, 1);
    chk("t1 byte1", bus.o_data_byte, 8'hA5);
    step();
    chk("t1 done state no valid", bus.o_valid, 0);
    chk("t1 done not yet", bus.rd_done, 0);
    step();
    chk("t1 rd_done pulse", bus.rd_done, 1);
    chk("t1 idle not busy", bus.rd_busy, 0);
    step();
    chk("t1 rd_done one cycle", bus.rd_done, 0);
    do_write(9'h001, 16'h1234, 2'b01);
    do_write(9'h001, 16'hAB00, 2'b10);
    start(10'h003, 5'd1);
    get_byte("t2 high byte", 8'hAB);
    wait_done("t2 done");
    start(10'h002, 5'd1);
    get_byte("t2 low byte kept", 8'h34);
    wait_done("t2b done");
    do_write(9'h1FF, 16'hBEEF, 2'b11);
    do_write(9'h000, 16'hCAFE, 2'b11);
    start(10'h3FE, 5'd4);
    get_byte("t3 b0", 8'hEF);
    get_byte("t3 b1", 8'hBE);
    get_byte("t3 wrap b2", 8'hFE);
    get_byte("t3 wrap b3", 8'hCA);
    wait_done("t3 done");
    for (int i = 0; i < 8; i++) do_write(9'(9'h010 + i), {8'(8'h41 + 2 * i), 8'(8'h40 + 2 * i)}, 2'b11);
    start(10'h020, 5'd16);
    hs = 0;
    cyc = 0;
    while (!bus.rd_done && cyc < 300) begin
      bus.rd_start = cyc == 5;
      bus.rd_addr = cyc == 5 ? 10'h000 : 10'h020;
      bus.i_ready = cyc % 4 == 0 || cyc % 4 == 3;
      if (bus.o_valid) begin
        chk("t4 stalled stream byte", bus.o_data_byte, 8'(8'h40 + hs));
        if (bus.i_ready) hs++;
      end
      step();
      cyc++;
    end
    bus.rd_start = 1'b0;
    bus.i_ready = 1'b1;
    chk("t4 done seen", bus.rd_done, 1);
    chk("t4 handshakes", hs, 16);
    step();
    chk("t4 rd_start ignored", bus.rd_busy, 0);
    start(10'h000, 5'd0);
    chk("t5 len0 no valid", bus.o_valid, 0);
    chk("t5 len0 busy", bus.rd_busy, 1);
    chk("t5 len0 done not yet", bus.rd_done, 0);
    step();
    chk("t5 len0 done 2 edges", bus.rd_done, 1);
    chk("t5 len0 still no valid", bus.o_valid, 0);
    step();
    start(10'h020, 5'd31);
    hs = 0;
    cyc = 0;
    while (!bus.rd_done && cyc < 100) begin
      if (bus.o_valid) hs++;
      step();
      cyc++;
    end
    chk("t5 clamp handshakes", hs, 16);
    step();
    start(10'h020, 5'd4);
    get_byte("t6 pre-reset byte", 8'h40);
    chk("t6 in emit", bus.o_valid, 1);
    reset = 1'b0;
    #1;
    chk("t6 reset o_valid", bus.o_valid, 0);
    chk("t6 reset rd_busy", bus.rd_busy, 0);
    chk("t6 reset o_data_byte", bus.o_data_byte, 0);
    step();
    reset = 1'b1;
    step();
    start(10'h020, 5'd2);
    get_byte("t6 reread b0", 8'h40);
    get_byte("t6 reread b1", 8'h41);
    wait_done("t6 done");
`ifdef MEM_RD_BYPASS_EN
    do_write(9'h005, 16'h0000, 2'b11);
    start(10'h00A, 5'd2);
    bus.wr_en = 1'b1;
    bus.wr_addr = 9'h005;
    bus.wr_data = 16'h7777;
    bus.wr_be = 2'b11;
    step();
    bus.wr_en = 1'b0;
    get_byte("byp b0", 8'h77);
    get_byte("byp b1", 8'h77);
    wait_done("byp done");
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
